// File: rtl/fc_mac_array.sv
// Pipelined multiply-accumulate array: one signed activation per beat against CH weights,
// N_IN beats accumulated at full precision, then shift/saturate/ReLU requantisation per channel.
module fc_mac_array #(
  parameter int DIN_W = 18,
  parameter int W_W   = 9,
  parameter int CH    = 16,
  parameter int N_IN  = 100,
  parameter int ACC_W = 36,
  parameter int SHIFT = 8,
  parameter int OUT_W = 18,
  parameter int RELU  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIN_W-1:0]              din,
  input  logic [CH-1:0][W_W-1:0]        weight,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH-1:0][OUT_W-1:0]      dout,
  output logic                          busy
);

  localparam int PW = DIN_W + W_W;
  localparam int CW = $clog2(N_IN + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prod_vld_q, prod_vld_d;
  logic          accept;
  logic          clr;
  logic          drain;

  // Floor shift, clamp to the output range, then optional ReLU.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [OUT_W-1:0]        r;
    s = a >>> SHIFT;
    if (s > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
    else if (s < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
    else                  r = s[OUT_W-1:0];
    if (RELU != 0 && r[OUT_W-1]) r = '0;
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_vld_d = 1'b0;
    clr        = 1'b0;
    drain      = 1'b0;
    accept     = (state_q == S_ACCUM) && in_valid;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d      = cnt_q + 1'b1;
          prod_vld_d = 1'b1;
          if (cnt_q == CW'(N_IN - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain   = 1'b1;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_vld_q <= prod_vld_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic signed [PW-1:0]    prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum;
    logic [OUT_W-1:0]        dout_q, dout_d;
    logic signed [PW-1:0]    din_x, w_x;

    assign din_x = $signed({{W_W{din[DIN_W-1]}}, din});
    assign w_x   = $signed({{DIN_W{weight[gi][W_W-1]}}, weight[gi]});

    // sum also feeds requantisation in DRAIN so the last product needs no extra cycle.
    always_comb begin
      prod_d = accept ? din_x * w_x : prod_q;
      sum    = acc_q + (prod_vld_q ? ACC_W'(prod_q) : '0);
      acc_d  = clr ? '0 : sum;
      dout_d = drain ? requant(sum) : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
        acc_q  <= '0;
        dout_q <= '0;
      end else begin
        prod_q <= prod_d;
        acc_q  <= acc_d;
        dout_q <= dout_d;
      end
    end

    assign dout[gi] = dout_q;
  end

endmodule

// File: tb/tb_fc_mac_array.sv
// Scoreboard bench for fc_mac_array: three instances cover the accumulate/saturate,
// ReLU and single-beat shift configurations.
module tb_fc_mac_array;

  localparam int CH = 4;
  localparam int DW = 18;
  localparam int WW = 9;
  localparam int OW = 18;
  localparam int NU = 3;

  typedef logic [CH-1:0][OW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                   start_s     [NU];
  logic                   in_valid_s  [NU];
  logic                   in_ready_s  [NU];
  logic [DW-1:0]          din_s       [NU];
  logic [CH-1:0][WW-1:0]  weight_s    [NU];
  logic                   out_valid_s [NU];
  logic                   out_ready_s [NU];
  vec_t                   dout_s      [NU];
  logic                   busy_s      [NU];

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t exp_q[$];
  int   job_din[$];
  int   job_w[CH];
  bit   vpat[$];

  always #5 clk = ~clk;

  // Unit 0: N_IN=4 SHIFT=0 RELU=0; unit 1: same with RELU=1; unit 2: N_IN=1 SHIFT=8 RELU=0.
  for (genvar gi = 0; gi < NU; gi++) begin : g_dut
    fc_mac_array #(
      .DIN_W(DW), .W_W(WW), .CH(CH),
      .N_IN ((gi == 2) ? 1 : 4),
      .ACC_W(36),
      .SHIFT((gi == 2) ? 8 : 0),
      .OUT_W(OW),
      .RELU ((gi == 1) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s[gi]),
      .in_valid (in_valid_s[gi]),
      .in_ready (in_ready_s[gi]),
      .din      (din_s[gi]),
      .weight   (weight_s[gi]),
      .out_valid(out_valid_s[gi]),
      .out_ready(out_ready_s[gi]),
      .dout     (dout_s[gi]),
      .busy     (busy_s[gi])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t model(input int u);
    vec_t   r;
    longint acc;
    longint s;
    int     sh;
    sh = (u == 2) ? 8 : 0;
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      foreach (job_din[b]) acc += longint'(job_din[b]) * longint'(job_w[c]);
      s = acc >>> sh;
      if (s > 131071)  s = 131071;
      if (s < -131072) s = -131072;
      if (u == 1 && s < 0) s = 0;
      r[c] = s[OW-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int u, input string tag);
    int b;
    int cyc;
    int cycles;
    bit v;
    bit acc_now;
    exp_q.push_back(model(u));
    start_s[u] = 1'b1;
    tick();
    start_s[u] = 1'b0;
    check({tag, " busy"}, busy_s[u], 1);
    check({tag, " in_ready"}, in_ready_s[u], 1);
    b   = 0;
    cyc = 0;
    while (b < job_din.size() && cyc < 64) begin
      v = (vpat.size() == 0) ? 1'b1 : vpat[cyc % vpat.size()];
      in_valid_s[u] = v;
      din_s[u]      = v ? DW'(job_din[b]) : DW'($urandom);
      for (int c = 0; c < CH; c++) weight_s[u][c] = v ? WW'(job_w[c]) : WW'($urandom);
      acc_now = v && in_ready_s[u];
      tick();
      if (acc_now) b++;
      cyc++;
    end
    in_valid_s[u] = 1'b0;
    check({tag, " beats"}, b, job_din.size());
    check({tag, " drain in_ready"}, in_ready_s[u], 0);
    // The cycle right after the accepting edge is cycle 1; out_valid must show in cycle 2.
    cycles = 1;
    while (!out_valid_s[u] && cycles < 10) begin
      tick();
      cycles++;
    end
    check({tag, " latency"}, cycles, 2);
  endtask

  task automatic collect(input int u, input string tag, input int hold, input bit poke_start);
    vec_t e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, " dout"}, dout_s[u], e);
    for (int i = 0; i < hold; i++) begin
      out_ready_s[u] = 1'b0;
      start_s[u]     = poke_start;
      tick();
      start_s[u] = 1'b0;
      check({tag, " hold out_valid"}, out_valid_s[u], 1);
      check({tag, " hold dout"}, dout_s[u], e);
      check({tag, " hold in_ready"}, in_ready_s[u], 0);
    end
    out_ready_s[u] = 1'b1;
    tick();
    out_ready_s[u] = 1'b0;
    check({tag, " out_valid drop"}, out_valid_s[u], 0);
    check({tag, " idle"}, busy_s[u], 0);
    $display("job %s unit %0d dout=%h expected=%h", tag, u, dout_s[u], e);
  endtask

  task automatic set_w(input int w);
    for (int c = 0; c < CH; c++) job_w[c] = w;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      start_s[u] = 1'b0; in_valid_s[u] = 1'b0; din_s[u] = '0;
      weight_s[u] = '0; out_ready_s[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int u = 0; u < NU; u++) begin
      check("reset in_ready", in_ready_s[u], 0);
      check("reset out_valid", out_valid_s[u], 0);
      check("reset busy", busy_s[u], 0);
      check("reset dout", dout_s[u], 0);
    end

    // Beats without start must be ignored.
    in_valid_s[0] = 1'b1;
    din_s[0]      = DW'(1000);
    for (int c = 0; c < CH; c++) weight_s[0][c] = WW'(100);
    repeat (3) begin
      tick();
      check("nostart in_ready", in_ready_s[0], 0);
      check("nostart busy", busy_s[0], 0);
    end
    in_valid_s[0] = 1'b0;

    job_din = '{1, 2, 3, 4};
    for (int c = 0; c < CH; c++) job_w[c] = c;
    run_job(0, "basic");
    collect(0, "basic", 0, 1'b0);

    job_din = '{131071, 131071, 131071, 131071};
    set_w(255);
    run_job(0, "sat_pos");
    collect(0, "sat_pos", 0, 1'b0);
    set_w(-256);
    run_job(0, "sat_neg");
    collect(0, "sat_neg", 0, 1'b0);
    run_job(1, "sat_relu");
    collect(1, "sat_relu", 0, 1'b0);

    set_w(1);
    job_din = '{-300};
    run_job(2, "floor_neg");
    collect(2, "floor_neg", 0, 1'b0);
    job_din = '{300};
    run_job(2, "floor_pos");
    collect(2, "floor_pos", 0, 1'b0);

    job_din = '{1, 2, 3, 4};
    for (int c = 0; c < CH; c++) job_w[c] = c;
    vpat = '{1, 0, 0, 1, 1, 0, 1};
    run_job(0, "bubbles");
    vpat.delete();
    collect(0, "bubbles", 5, 1'b0);

    for (int j = 0; j < 3; j++) begin
      job_din.delete();
      for (int b = 0; b < 4; b++) job_din.push_back(int'($urandom_range(0, 1000)) - 500);
      for (int c = 0; c < CH; c++) job_w[c] = int'($urandom_range(0, 511)) - 256;
      run_job(0, "rand_acc");
      collect(0, "rand_acc", j, 1'b0);
      run_job(1, "rand_relu");
      collect(1, "rand_relu", 0, 1'b0);
      job_din = '{int'($urandom_range(0, 262143)) - 131072};
      run_job(2, "rand_shift");
      collect(2, "rand_shift", 0, 1'b0);
    end

    // Abort a job after two beats with an asynchronous reset.
    start_s[0] = 1'b1;
    tick();
    start_s[0]    = 1'b0;
    in_valid_s[0] = 1'b1;
    din_s[0]      = DW'(5000);
    for (int c = 0; c < CH; c++) weight_s[0][c] = WW'(77);
    tick();
    tick();
    in_valid_s[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("abort in_ready", in_ready_s[0], 0);
    check("abort busy", busy_s[0], 0);
    check("abort out_valid", out_valid_s[0], 0);
    check("abort dout", dout_s[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("abort no out_valid", out_valid_s[0], 0);
    end

    job_din = '{1, 1, 1, 1};
    set_w(1);
    run_job(0, "after_abort");
    collect(0, "after_abort", 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
